weight_bram_sequencer: RTL
==========================

// Module: weight_bram_sequencer
// PURPOSE
//  Owns one negedge-clocked 28x16 weight BRAM and shares it between a host write (load) port and a neuron-side streaming read port.
//  Sweeps addresses 0..DEPTH-1 into a valid/ready weight stream for the MAC datapath. Arbitrates host writes against read sweeps.
//  Sits between the host/config interface and each Weight BRAM instance in the ANN layer.
// PARAMETERS
//  DEPTH  28  words in the BRAM; sweep length
//  AW     5   address width (2**AW >= DEPTH)
//  DW     16  weight word width
// PORTS
//  CLK        in   1   clock; all logic here on posedge. The BRAM samples on negedge.
//  RST_N      in   1   asynchronous, active-low reset
//  RD_START   in   1   pulse: begin sweep 0..DEPTH-1
//  RD_BUSY    out  1   sweep in progress
//  W_DATA     out  DW  weight word
//  W_VALID    out  1   W_DATA valid
//  W_READY    in   1   consumer accepts the beat when W_VALID&&W_READY
//  W_LAST     out  1   marks beat for address DEPTH-1
//  RD_DONE    out  1   1-cycle pulse, cycle after last beat accepted
//  WR_REQ     in   1   host write request; held with WR_ADDR/WR_DATA until WR_ACK
//  WR_ADDR    in   AW  host write address
//  WR_DATA    in   DW  host write data
//  WR_ACK     out  1   1-cycle pulse: request consumed
//  WR_ERR     out  1   1-cycle pulse with WR_ACK when WR_ADDR>=DEPTH (write dropped)
//  BRAM_ADDR  out  AW  to BRAM ADDR (registered)
//  BRAM_DI    out  DW  to BRAM DI (registered)
//  BRAM_EN    out  1   to BRAM EN (registered)
//  BRAM_WE    out  1   to BRAM WE (registered)
//  BRAM_DO    in   DW  from BRAM DO; updates only on negedge with EN=1,WE=0, holds otherwise
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE; all outputs 0; addr counter=0; pending-start flag=0. Takes effect mid-sweep or mid-write. The in-flight beat is discarded and no RD_DONE is issued.
//  BRAM timing: BRAM_* registered at posedge k, sampled by BRAM at negedge mid-cycle k. Read data on BRAM_DO is captured into W_DATA at posedge k+1. Read latency is 1 cycle.
//  FSM states IDLE, WRITE, READ, DONE.
//   IDLE: WR_REQ has priority.
//    WR_REQ -> WRITE; drive EN=1, WE=1, ADDR=WR_ADDR, DI=WR_DATA. If WR_ADDR>=DEPTH, drive EN=0 instead.
//    Else if RD_START or pending-start -> READ; clear pending.
//   WRITE (1 cycle): WR_ACK=1, plus WR_ERR if out of range; EN, WE -> 0; return to IDLE.
//    RD_START seen in IDLE-with-WR_REQ or in WRITE sets pending-start.
//   READ: RD_BUSY=1. Issue condition: issue = (cnt<DEPTH) && (!W_VALID || W_READY).
//    On issue: EN=1, WE=0, ADDR=cnt, cnt++. Otherwise EN=0, so DO holds.
//    A beat issued at k lands at k+1: W_VALID=1, W_DATA=BRAM_DO, W_LAST=(addr==DEPTH-1).
//    W_VALID/W_DATA/W_LAST stay stable while W_VALID && !W_READY.
//    A beat accepted with no new issue clears W_VALID.
//    Sustained throughput is 1 beat/cycle with W_READY=1. First beat appears 2 cycles after the RD_START pulse edge.
//    Accepting the W_LAST beat -> DONE.
//   DONE (1 cycle): RD_DONE=1, RD_BUSY=0, cnt=0 -> IDLE.
//  RD_START while RD_BUSY or in DONE: ignored.
//  WR_REQ during READ/DONE: no ack; request waits until IDLE. The host must hold it.
//  The counter never wraps; cnt stops at DEPTH. AW bits exist but addresses DEPTH..2**AW-1 are never read.
// TESTING
//  1 Preload mem[i]=i+100; RD_START, W_READY=1 -> 28 consecutive beats 100..127, W_LAST on 127, RD_DONE next cycle, RD_BUSY low.
//  2 Sweep with W_READY toggling 1,0,0,1... -> no beat lost or duplicated. W_DATA stable while stalled. BRAM_EN=0 on stalled cycles.
//  3 WR_REQ addr 5 data 16'hBEEF; then sweep -> WR_ACK 1 pulse; beat 5 = 16'hBEEF; others unchanged.
//  4 WR_REQ and RD_START same cycle in IDLE -> write acked first, sweep starts after. Beat for the written address shows the new data.
//  5 WR_REQ addr 30 -> WR_ACK and WR_ERR pulse, BRAM_WE never 1; WR_REQ asserted mid-sweep -> no ack until after RD_DONE.
//  6 RST_N low after beat 10 -> all outputs 0 immediately; no RD_DONE. New RD_START after release -> full sweep from address 0.

Source files
------------

// File: rtl/weight_bram_sequencer.sv
// Weight BRAM sequencer: shares one negedge-sampled weight BRAM between a
// host write port and a valid/ready streaming read sweep over 0..DEPTH-1.
module weight_bram_sequencer #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_start_i,
  output logic          rd_busy_o,
  output logic [DW-1:0] w_data_o,
  output logic          w_valid_o,
  input  logic          w_ready_i,
  output logic          w_last_o,
  output logic          rd_done_o,
  input  logic          wr_req_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          wr_ack_o,
  output logic          wr_err_o,
  output logic [AW-1:0] bram_addr_o,
  output logic [DW-1:0] bram_di_o,
  output logic          bram_en_o,
  output logic          bram_we_o,
  input  logic [DW-1:0] bram_do_i
);

  // One extra bit so the counter can park at DEPTH even when DEPTH == 2**AW.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t        state_q;
  logic [AW:0]   cnt_q;
  logic          pend_q;      // RD_START seen while a write was being served
  logic          do_pend_q;   // BRAM DO holds a read not yet moved to W_DATA
  logic          rd_busy_q;
  logic          rd_done_q;
  logic [DW-1:0] w_data_q;
  logic          w_valid_q;
  logic          w_last_q;
  logic          wr_ack_q;
  logic          wr_err_q;
  logic [AW-1:0] bram_addr_q;
  logic [DW-1:0] bram_di_q;
  logic          bram_en_q;
  logic          bram_we_q;

  logic in_range;
  logic adv;
  logic issue;
  logic at_last;

  // The output register can take a new beat when it is empty or being drained.
  // A read is only issued in the same condition; because DO holds while EN=0,
  // a stalled read simply waits in the BRAM output until the register frees up.
  assign in_range = ({1'b0, wr_addr_i} < DEPTH_C);
  assign adv      = !w_valid_q || w_ready_i;
  assign issue    = (cnt_q < DEPTH_C) && adv;
  assign at_last  = ({1'b0, bram_addr_q} == (DEPTH_C - 1'b1));

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      do_pend_q   <= 1'b0;
      rd_busy_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      w_data_q    <= '0;
      w_valid_q   <= 1'b0;
      w_last_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      bram_addr_q <= '0;
      bram_di_q   <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
    end else begin
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr_req_i) begin
            state_q     <= S_WRITE;
            bram_en_q   <= in_range;
            bram_we_q   <= in_range;
            bram_addr_q <= wr_addr_i;
            bram_di_q   <= wr_data_i;
            wr_ack_q    <= 1'b1;
            wr_err_q    <= !in_range;
            if (rd_start_i) pend_q <= 1'b1;
          end else if (rd_start_i || pend_q) begin
            state_q   <= S_READ;
            pend_q    <= 1'b0;
            rd_busy_q <= 1'b1;
            cnt_q     <= '0;
            do_pend_q <= 1'b0;
          end
        end
        S_WRITE: begin
          bram_en_q <= 1'b0;
          bram_we_q <= 1'b0;
          if (rd_start_i) pend_q <= 1'b1;
          state_q <= S_IDLE;
        end
        S_READ: begin
          bram_we_q <= 1'b0;
          bram_en_q <= issue;
          if (issue) begin
            bram_addr_q <= cnt_q[AW-1:0];
            cnt_q       <= cnt_q + 1'b1;
          end
          if (w_valid_q && w_ready_i && w_last_q) begin
            state_q   <= S_DONE;
            rd_busy_q <= 1'b0;
            rd_done_q <= 1'b1;
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
            do_pend_q <= 1'b0;
          end else if (adv) begin
            do_pend_q <= issue;
            if (do_pend_q) begin
              w_valid_q <= 1'b1;
              w_data_q  <= bram_do_i;
              w_last_q  <= at_last;
            end else begin
              w_valid_q <= 1'b0;
              w_last_q  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_busy_o   = rd_busy_q;
  assign rd_done_o   = rd_done_q;
  assign w_data_o    = w_data_q;
  assign w_valid_o   = w_valid_q;
  assign w_last_o    = w_last_q;
  assign wr_ack_o    = wr_ack_q;
  assign wr_err_o    = wr_err_q;
  assign bram_addr_o = bram_addr_q;
  assign bram_di_o   = bram_di_q;
  assign bram_en_o   = bram_en_q;
  assign bram_we_o   = bram_we_q;

endmodule
